fetch_stage: RTL

Instruction-fetch front end of the 5-stage core: owns the PC, issues requests to instruction memory over a request/ready handshake, and drives the IF/ID pipeline register. It consumes the hold signals produced by load-use hazard detection (`pc_write`, `if_id_write`) and the branch redirect from EX. It also absorbs instruction-memory wait states and redirects that arrive while a fetch is outstanding, using a one-entry hold buffer and a drain state.

---
 rtl/core_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the fetch front end.
// This package holds the reset and NOP constants, the fetch FSM states and the IF/ID payload.
package core_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a write enable and a synchronous flush.
// Reset and flush both load NOP. Flush keeps the held PC and takes priority over the enable.
module if_id_reg
    import core_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_en,
    input  logic   i_flush,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q.pc    <= 32'h0;
            r_q.instr <= NOP_INSTR;
            r_q.valid <= 1'b0;
        end else if (i_flush) begin
            r_q.instr <= NOP_INSTR;
            r_q.valid <= 1'b0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, imem request/ready handshake, hold buffer and redirect drain.
// The IF/ID register sits in if_id_reg. The FSM, PC, buffer and pending PC live here.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_buf, w_buf_nxt;
    logic [31:0]  r_pend_pc, w_pend_nxt;
    logic         w_ifid_en, w_flush;
    if_id_t       w_ifid_d, w_ifid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC;
            r_buf     <= 32'h0;
            r_pend_pc <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_buf     <= w_buf_nxt;
            r_pend_pc <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_nxt   = r_buf;
        w_pend_nxt  = r_pend_pc;
        w_ifid_en   = 1'b0;
        w_flush     = 1'b0;
        w_ifid_d    = w_ifid_q;
        case (r_state)
            FETCH: begin
                if (imem_ready) begin
                    if (branch_taken) begin
                        w_pc_nxt = branch_target;
                        w_flush  = 1'b1;
                    end else if (if_id_write) begin
                        w_ifid_en = 1'b1;
                        w_ifid_d  = '{pc: r_pc, instr: imem_rdata, valid: 1'b1};
                        if (pc_write) w_pc_nxt = r_pc + 32'd4;
                    end else begin
                        w_buf_nxt   = imem_rdata;
                        w_state_nxt = HOLD;
                    end
                end else begin
                    if (branch_taken) begin
                        w_pend_nxt  = branch_target;
                        w_flush     = 1'b1;
                        w_state_nxt = DRAIN;
                    end else if (if_id_write) begin
                        // wait-state bubble: only the valid bit drops
                        w_ifid_en      = 1'b1;
                        w_ifid_d.valid = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_flush     = 1'b1;
                    w_state_nxt = FETCH;
                end else if (if_id_write) begin
                    w_ifid_en   = 1'b1;
                    w_ifid_d    = '{pc: r_pc, instr: r_buf, valid: 1'b1};
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = FETCH;
                end
            end
            DRAIN: begin
                // the old request is still on the bus at r_pc; a newer redirect replaces the pending target
                w_flush = 1'b1;
                if (branch_taken) w_pend_nxt = branch_target;
                if (imem_ready) begin
                    w_pc_nxt    = branch_taken ? branch_target : r_pend_pc;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_ifid_en),
        .i_flush (w_flush),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign imem_req    = rst_n && (r_state != HOLD);
    assign imem_addr   = r_pc;
    assign if_id_pc    = w_ifid_q.pc;
    assign if_id_instr = w_ifid_q.instr;
    assign if_id_valid = w_ifid_q.valid;

endmodule
